// File: rtl/calc_resp_engine.sv
// ============================================================================
// Module      : calc_resp_engine
// Description : Two-operand command engine (add, subtract, logical shifts)
//               that returns a one-cycle response code and result word.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module calc_resp_engine (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [3:0] C_CMD_NOP  = 4'd0;
    localparam logic [3:0] C_CMD_ADD  = 4'd1;
    localparam logic [3:0] C_CMD_SUB  = 4'd2;
    localparam logic [3:0] C_CMD_SHL  = 4'd5;
    localparam logic [3:0] C_CMD_SHR  = 4'd6;

    localparam logic [1:0] C_RESP_NONE = 2'd0;
    localparam logic [1:0] C_RESP_OK   = 2'd1;
    localparam logic [1:0] C_RESP_OVF  = 2'd2;
    localparam logic [1:0] C_RESP_INV  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP2  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cmd;
    logic [3:0]  w_cmd_nxt;
    logic [31:0] r_op1;
    logic [31:0] w_op1_nxt;
    logic [31:0] r_op2;
    logic [31:0] w_op2_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic [1:0]  r_resp;
    logic [1:0]  w_resp_nxt;
    logic [31:0] r_data;
    logic [31:0] w_data_nxt;

    logic [32:0] w_sum;
    logic [31:0] w_diff;
    logic        w_borrow;
    logic        w_big_shift;
    logic        w_done;

    assign w_sum       = {1'b0, r_op1} + {1'b0, r_op2};
    assign w_diff      = r_op1 - r_op2;
    assign w_borrow    = (r_op1 < r_op2);
    assign w_big_shift = |r_op2[31:5];

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cmd   <= C_CMD_NOP;
            r_op1   <= 32'd0;
            r_op2   <= 32'd0;
            r_cnt   <= 5'd0;
            r_resp  <= C_RESP_NONE;
            r_data  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_op1   <= w_op1_nxt;
            r_op2   <= w_op2_nxt;
            r_cnt   <= w_cnt_nxt;
            r_resp  <= w_resp_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Response registers default to zero so every result lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_op1_nxt   = r_op1;
        w_op2_nxt   = r_op2;
        w_cnt_nxt   = r_cnt;
        w_resp_nxt  = C_RESP_NONE;
        w_data_nxt  = 32'd0;
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (req_cmd_in != C_CMD_NOP) begin
                    w_cmd_nxt   = req_cmd_in;
                    w_op1_nxt   = req_data_in;
                    w_state_nxt = OP2;
                end
            end
            OP2: begin
                w_op2_nxt   = req_data_in;
                w_cnt_nxt   = req_data_in[4:0];
                w_state_nxt = EXEC;
            end
            EXEC: begin
                w_done = 1'b1;
                case (r_cmd)
                    C_CMD_ADD: begin
                        if (w_sum[32]) begin
                            w_resp_nxt = C_RESP_OVF;
                        end else begin
                            w_resp_nxt = C_RESP_OK;
                            w_data_nxt = w_sum[31:0];
                        end
                    end
                    C_CMD_SUB: begin
                        if (w_borrow) begin
                            w_resp_nxt = C_RESP_OVF;
                        end else begin
                            w_resp_nxt = C_RESP_OK;
                            w_data_nxt = w_diff;
                        end
                    end
                    C_CMD_SHL, C_CMD_SHR: begin
                        // op1 doubles as the shift accumulator, one bit per cycle.
                        if (w_big_shift) begin
                            w_resp_nxt = C_RESP_OK;
                        end else if (r_cnt != 5'd0) begin
                            w_done    = 1'b0;
                            w_cnt_nxt = r_cnt - 5'd1;
                            w_op1_nxt = (r_cmd == C_CMD_SHL) ? {r_op1[30:0], 1'b0}
                                                             : {1'b0, r_op1[31:1]};
                        end else begin
                            w_resp_nxt = C_RESP_OK;
                            w_data_nxt = r_op1;
                        end
                    end
                    default: begin
                        w_resp_nxt = C_RESP_INV;
                    end
                endcase
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign out_resp = r_resp;
    assign out_data = r_data;
    assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/calc_resp_engine.md
CALC_RESP_ENGINE -- requirements
Module: calc_resp_engine

Interface
REQ-001 c_clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 req_cmd_in  input  4  command: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right, all others invalid.
REQ-004 req_data_in  input  32  operand 1 in the command cycle; operand 2 in the following cycle.
REQ-005 out_resp  output  2  response code: 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
REQ-006 out_data  output  32  result; meaningful only when out_resp=1.
REQ-007 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-008 FSM states SHALL be IDLE, OP2, EXEC and nothing else.
REQ-009 IDLE: on an edge with req_cmd_in!=0, SHALL latch cmd and op1=req_data_in, then go to OP2; with req_cmd_in=0, SHALL stay in IDLE.
REQ-010 OP2: on the next edge, SHALL latch op2=req_data_in, ignore req_cmd_in, then go to EXEC.
REQ-011 EXEC, add: 33-bit op1+op2; carry set -> resp 2, data 0; otherwise resp 1, data = sum[31:0]; completes on the first EXEC edge.
REQ-012 EXEC, subtract: op1-op2; op1<op2 (unsigned) -> resp 2, data 0; otherwise resp 1, data = difference; completes on the first EXEC edge.
REQ-013 EXEC, shift left/right, logical, zero fill: if op2[31:5]!=0, SHALL complete on the first EXEC edge with resp 1, data 0.
REQ-014 Otherwise the shift SHALL iterate one bit position per edge, op2[4:0] times, then complete on the following edge; op2[4:0]=0 completes on the first EXEC edge with data=op1.
REQ-015 EXEC, invalid cmd: resp 3, data 0; completes on the first EXEC edge.
REQ-016 On the completion edge, SHALL register out_resp/out_data and return to IDLE.
REQ-017 out_resp/out_data SHALL hold the result for exactly one cycle, then return to 0 on the next edge, unless a new result is registered on that same edge.
REQ-018 Latency: cmd sampled at edge k -> result registered at edge k+2 for add/sub/invalid/large shift, and at edge k+2+op2[4:0] for iterative shifts.
REQ-019 req_cmd_in SHALL be ignored in OP2 and EXEC; such commands are dropped with no response.
REQ-020 A command SHALL be accepted on the edge that clears the previous response, i.e. the edge after the completion edge (back-to-back throughput).
REQ-021 Data output SHALL be 0 whenever out_resp!=1.

Reset
REQ-022 reset_n low SHALL immediately force: FSM to IDLE; out_resp=0, out_data=0, busy=0; latched cmd, operands and shift count cleared.
REQ-023 Reset asserted mid-operation (OP2 or EXEC) SHALL abort it; no response is produced after release.
REQ-024 After reset_n rises, the first rising edge SHALL be able to accept a command.

Verification
REQ-025 cmd 1, op1 0x00000064, op2 0x00000027 -> resp 1, data 0x0000008B, at edge k+2, one cycle wide.
REQ-026 cmd 1, op1 0xFFFFFFFF, op2 0x1 -> resp 2, data 0. Then cmd 2, op1 0x22, op2 0x23 -> resp 2, data 0.
REQ-027 cmd 5, op1 0x3, op2 0x2 -> resp 1, data 0xC at edge k+4. Then cmd 6, op1 0xC, op2 0x2 -> resp 1, data 0x3 at edge k+4. Then cmd 5, op2 0x40 -> resp 1, data 0 at edge k+2.
REQ-028 cmd 0x3, op1 0x5, op2 0x1 -> resp 3, data 0. Then cmd 0 for 10 cycles -> out_resp stays 0 and busy stays 0.
REQ-029 Shift cmd 5 with op2 0x1F, then cmd 1 presented during EXEC -> add dropped; only the shift result appears, at edge k+33.
REQ-030 Shift cmd 5 with op2 0x10, reset_n pulsed low at edge k+5 -> outputs 0 immediately, no response within 20 cycles. A subsequent add 5+1 -> resp 1, data 6.
